// File: rtl/data_mem.sv
// Byte-addressable little-endian data memory: 64-bit stores on the rising clock edge,
// combinational 64-bit loads at any byte address, asynchronous active-low clear.
module data_mem #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wrt_data,
    input  logic              mem_write,
    input  logic              mem_read,
    output logic [DATA_W-1:0] read_data
);

    localparam int LANES = DATA_W / 8;
    localparam int IDX_W = $clog2(MEM_BYTES);

    // Flattened view of the byte array, byte j at bits 8j+7:8j.
    logic [MEM_BYTES*8-1:0] mem_flat;

    genvar gi;

    // Each location decides on its own whether it falls inside the store window
    // [address, address+7]; the window is computed without wrap-around.
    generate
        for (gi = 0; gi < MEM_BYTES; gi++) begin : g_byte
            localparam logic [ADDR_W-1:0] BYTE_ADDR = ADDR_W'(gi);

            logic [ADDR_W-1:0] offset;
            logic              hit;
            logic [2:0]        lane;
            logic [7:0]        byte_reg;
            logic [7:0]        byte_next;

            assign offset    = BYTE_ADDR - address;
            assign hit       = (address <= BYTE_ADDR) && (offset < ADDR_W'(LANES));
            assign lane      = offset[2:0];
            assign byte_next = wrt_data[lane*8 +: 8];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    byte_reg <= 8'h00;
                end else if (mem_write && hit) begin
                    byte_reg <= byte_next;
                end
            end

            assign mem_flat[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    // Load lanes: lane i reads location address+i, or 0 once past the last byte.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ADDR_W:0] rd_addr;
            logic            in_range;
            logic [7:0]      rd_byte;

            assign rd_addr  = {1'b0, address} + (ADDR_W+1)'(gi);
            assign in_range = rd_addr < (ADDR_W+1)'(MEM_BYTES);
            assign rd_byte  = in_range ? mem_flat[rd_addr[IDX_W-1:0]*8 +: 8] : 8'h00;

            assign read_data[gi*8 +: 8] = mem_read ? rd_byte : 8'h00;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed cases followed by random loads/stores/reset pulses,
// all compared against a byte-array model of the memory.
module tb_data_mem;

    localparam int MEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] address = '0;
    logic [63:0] wrt_data = '0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [63:0] read_data;

    int total = 0;
    int bad = 0;

    logic [7:0] model [MEM_BYTES];

    data_mem #(.MEM_BYTES(MEM_BYTES), .ADDR_W(64), .DATA_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .wrt_data  (wrt_data),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .read_data (read_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [63:0] a);
        logic [63:0] r;
        logic [64:0] ai;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            ai = {1'b0, a} + 65'(i);
            if (ai < 65'(MEM_BYTES)) r[i*8 +: 8] = model[int'(ai)];
        end
        return r;
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [63:0] d);
        logic [64:0] ai;
        for (int i = 0; i < 8; i++) begin
            ai = {1'b0, a} + 65'(i);
            if (ai < 65'(MEM_BYTES)) model[int'(ai)] = d[i*8 +: 8];
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        address   = a;
        wrt_data  = d;
        mem_write = 1'b1;
        @(posedge clk);
        if (reset) model_write(a, d);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [63:0] a, input logic [63:0] exp);
        mem_read = 1'b1;
        address  = a;
        #1;
        check_val(tag, read_data, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] a, d, exp;
        logic        we, re, rp;
        int          sel;

        model_clear();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // reset state
        read_check("rst_a0", 64'd0, 64'd0);
        read_check("rst_a8", 64'd8, 64'd0);

        // basic store / load
        do_write(64'd4, 64'd3);
        read_check("basic_rd", 64'd4, 64'd3);
        @(negedge clk);
        check_val("basic_hold", read_data, 64'd3);
        mem_read = 1'b0;
        #1;
        check_val("basic_rd_off", read_data, 64'd0);

        // little-endian and overlap
        do_write(64'd0, 64'h1122334455667788);
        read_check("le_a0", 64'd0, 64'h1122334455667788);
        read_check("le_a1", 64'd1, 64'h0011223344556677);
        do_write(64'd4, 64'hFFFFFFFFFFFFFFFF);
        read_check("ovl_a0", 64'd0, 64'hFFFFFFFF55667788);

        // same-cycle read and write, no bypass
        do_write(64'd16, 64'd5);
        @(negedge clk);
        read_check("rw_before", 64'd16, 64'd5);
        wrt_data  = 64'd9;
        mem_write = 1'b1;
        #1;
        check_val("rw_pre_edge", read_data, 64'd5);
        @(posedge clk);
        model_write(64'd16, 64'd9);
        #1;
        mem_write = 1'b0;
        check_val("rw_after", read_data, 64'd9);

        // upper bound, no wrap
        do_write(64'd252, 64'hAABBCCDDEEFF0011);
        read_check("bound_252", 64'd252, 64'h00000000EEFF0011);
        read_check("bound_0", 64'd0, 64'hFFFFFFFF55667788);
        do_write(64'd300, 64'h123456789ABCDEF0);
        read_check("oob_300", 64'd300, 64'd0);
        read_check("oob_252", 64'd252, 64'h00000000EEFF0011);
        do_write(64'hFFFFFFFFFFFFFFFC, 64'h0102030405060708);
        read_check("wrap_a0", 64'd0, 64'hFFFFFFFF55667788);
        read_check("wrap_top", 64'hFFFFFFFFFFFFFFFC, 64'd0);

        // mid-operation reset between edges, then a blocked write
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        read_check("mrst_a0", 64'd0, 64'd0);
        read_check("mrst_a16", 64'd16, 64'd0);
        wrt_data  = 64'hDEADBEEFCAFEF00D;
        address   = 64'd32;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        reset = 1'b1;
        #1;
        check_val("mrst_blocked", read_data, 64'd0);

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            sel = $urandom_range(0, 19);
            if (sel == 0)      a = {$urandom, $urandom};
            else if (sel == 1) a = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
            else               a = 64'($urandom_range(0, 270));
            d  = {$urandom, $urandom};
            we = ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 3) != 0);
            rp = ($urandom_range(0, 39) == 0);
            address   = a;
            wrt_data  = d;
            mem_write = we;
            mem_read  = re;
            if (rp) begin
                reset = 1'b0;
                model_clear();
            end
            #1;
            exp = re ? model_read(a) : 64'd0;
            check_val("rnd_pre", read_data, exp);
            $display("txn %0d addr=%h we=%0d re=%0d rst=%0d data=%h rd=%h", n, a, we, re, rp, d, read_data);
            @(posedge clk);
            if (we && reset) model_write(a, d);
            #1;
            exp = re ? model_read(a) : 64'd0;
            check_val("rnd_post", read_data, exp);
            mem_write = 1'b0;
            reset = 1'b1;
        end

        // full sweep of the array after random traffic
        for (int k = 0; k < MEM_BYTES; k += 8) begin
            read_check("sweep", 64'(k), model_read(64'(k)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Byte-addressable data memory for the single-cycle 64-bit processor datapath; serves load and store doublewords from the execute/memory stage.
- Stores and loads one 64-bit doubleword per access, little-endian, at any byte address (no alignment requirement).
- Writes are synchronous to the clock; reads are combinational.

Parameters:
- MEM_BYTES, 256, number of byte locations; must be a power of two ≥ 8.
- ADDR_W, 64, width of the address port.
- DATA_W, 64, access width in bits; fixed at 64 (8 bytes).

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all memory bytes to 0.
- address  input  64  byte address of the lowest-order byte of the doubleword.
- wrt_data  input  64  store data.
- mem_write  input  1  store enable, sampled at the rising clk edge.
- mem_read  input  1  load enable, combinational.
- read_data  output  64  load result.

Behaviour:
- Storage:
  - MEM_BYTES × 8-bit array.
  - Doubleword at address A = bytes A (bits 7:0) through A+7 (bits 63:56), little-endian.
- Reset:
  - When reset = 0, every byte clears to 0 immediately, without waiting for a clock edge.
  - While reset is held low, writes are blocked.
  - read_data is 0 during reset, because the array is 0.
- Write:
  - On a rising clk edge with reset = 1 and mem_write = 1, bytes A..A+7 take wrt_data.
  - Byte i of the doubleword (bits 8i+7:8i) is written to location A+i.
- Read:
  - mem_read = 1: read_data = {byte[A+7],…,byte[A]}, combinationally; it follows address and array changes with no clock latency.
  - mem_read = 0: read_data = 0.
- Read and write in the same cycle, same address:
  - Before the edge, read_data shows the old contents.
  - After the edge, it shows the new contents, since the read is combinational from the array.
  - No internal bypass.
- mem_read and mem_write both high is legal; they act independently per the rules above.
- Range:
  - A byte access is in range when A+i < MEM_BYTES; upper address bits above log2(MEM_BYTES) are not ignored.
  - Out-of-range write bytes are dropped; in-range bytes of a partially out-of-range access are still written.
  - Out-of-range read bytes return 0.
- No wrap-around past MEM_BYTES−1.
- Unaligned addresses (e.g. 4) are fully supported and overlap neighbouring doublewords.
- No X is ever driven on read_data after reset has been asserted once.

Test Plan:
- Reset: hold reset = 0, then release; mem_read = 1, address = 0 and address = 8 → read_data = 0 for both.
- Basic store/load:
  - mem_write = 1, address = 4, wrt_data = 3, rising clk edge; then mem_read = 1 → read_data = 3.
  - Drop mem_write → read_data stays 3.
  - mem_read = 0 → read_data = 0.
- Little-endian/overlap:
  - Write 0x1122334455667788 at address 0.
  - Read address 0 → 0x1122334455667788.
  - Read address 1 → 0x0011223344556677.
  - Write 0xFF…FF at address 4, then read address 0 → 0xFFFFFFFF55667788.
- Same-cycle read/write:
  - mem_read = 1, address = 16 holding 5; apply wrt_data = 9, mem_write = 1.
  - read_data = 5 before the clk edge, 9 after.
- Bounds (MEM_BYTES = 256):
  - Write 0xAABBCCDDEEFF0011 at address 252, then read 252 → 0x00000000EEFF0011.
  - Write to address 300 → no array change; read 300 → 0.
- Mid-operation reset:
  - With data stored, pulse reset low between clock edges → all reads return 0 immediately.
  - A write with reset low at the edge has no effect.
